// File: rtl/mult_seq.sv
// mult_seq: sequential radix-2 shift-add multiplier, signed or unsigned, one bit per cycle
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sign,
    input  logic                 opn_valid,
    input  logic                 res_ready,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, mplier, a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH:0]       sum;
    logic [CW-1:0]        cnt;
    logic                 neg, last;

    assign a_mag   = (sign && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (sign && b[WIDTH-1]) ? -b : b;
    assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_nxt = {sum, acc[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: a dropped request aborts CALC even on its final edge
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = opn_valid ? CALC : IDLE;
            CALC:    state_nxt = !opn_valid ? IDLE : (last ? DONE : CALC);
            DONE:    state_nxt = (res_ready || !opn_valid) ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-add iteration and result load with sign fix-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (state == IDLE && opn_valid) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC && opn_valid) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) result <= neg ? -acc_nxt : acc_nxt;
        end
    end

    // Registered status flags follow the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            res_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end
endmodule
